// File: rtl/sb_pkg.sv
// Shared types and default sizing for the store buffer.
package sb_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 8;
  localparam int unsigned SB_DW    = 8;

  typedef enum logic {
    RUN,
    FLUSH
  } sb_state_e;

  // One parked store; widths follow the package defaults above.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU request/response and memory port bundle of the store buffer.
// master = datapath/memory side, slave = store_buffer.
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int unsigned AW = SB_AW,
  parameter int unsigned DW = SB_DW
);

  logic          cpu_req_valid;
  logic          cpu_req_write;
  logic [AW-1:0] cpu_req_addr;
  logic [DW-1:0] cpu_req_wdata;
  logic          cpu_req_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rdata_valid;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_write;
  logic [DW-1:0] mem_read_data;

  modport master (
    output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_rdata, cpu_rdata_valid,
    input  mem_address, mem_write_data, mem_read_write,
    output mem_read_data
  );

  modport slave (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_rdata, cpu_rdata_valid,
    output mem_address, mem_write_data, mem_read_write,
    input  mem_read_data
  );

endinterface

// File: rtl/sb_match.sv
// Parallel address compare over the occupied FIFO slots. Reports whether any
// pending store matches and the age of the youngest match (0 = entry just
// below tail).
module sb_match #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned AW    = 8,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic [AW-1:0] entry_addr [DEPTH],
  input  logic [PW-1:0] tail,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [PW-1:0] age
);

  logic [PW-1:0] slot;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit  = 1'b0;
    age  = '0;
    slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = tail - PW'(DEPTH - 1 - i) - PW'(1);
      if ((CW'(DEPTH - 1 - i) < count) && (entry_addr[slot] == addr)) begin
        hit = 1'b1;
        age = PW'(DEPTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of a single-cycle data memory. Stores are parked in
// an in-order FIFO and drained one per cycle whenever no load owns the port.
// Loads are checked against pending stores.
// Optional macro SB_FORWARD_EN: matching loads take the youngest pending
// store data; otherwise matching loads stall until the match has drained.
// Entry storage uses the package entry layout, so AW/DW must track
// SB_AW/SB_DW.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  store_buffer_if.slave            bus,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_state_e     state_q, state_d;
  sb_entry_t     entry_q [DEPTH];
  logic [AW-1:0] entry_addr [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] rdata_q;
  logic          rdata_valid_q;
  logic          flush_done_q;

  logic          match_hit;
  logic [PW-1:0] match_age;
  logic          load_ok;
  logic [DW-1:0] load_data;
  logic          ready;
  logic          store_acc;
  logic          load_acc;
  logic          drain;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign flush_done = flush_done_q;

  assign bus.cpu_rdata       = rdata_q;
  assign bus.cpu_rdata_valid = rdata_valid_q;
  assign bus.cpu_req_ready   = ready;

  // Expose only the address field of each slot to the comparator.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_addr[i] = entry_q[i].addr;
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .entry_addr (entry_addr),
    .tail       (tail_q),
    .count      (count_q),
    .addr       (bus.cpu_req_addr),
    .hit        (match_hit),
    .age        (match_age)
  );

`ifdef SB_FORWARD_EN
  logic [PW-1:0] fwd_slot;

  // Matching loads are served from the youngest pending store.
  always_comb begin
    fwd_slot  = tail_q - match_age - PW'(1);
    load_ok   = 1'b1;
    load_data = match_hit ? entry_q[fwd_slot].data : bus.mem_read_data;
  end
`else
  logic unused_age;
  assign unused_age = ^match_age;

  // Matching loads wait for the store to reach memory; data comes only from memory.
  always_comb begin
    load_ok   = !match_hit;
    load_data = bus.mem_read_data;
  end
`endif

  // Request handshake and memory port arbitration: an accepted load owns the
  // port, otherwise the FIFO head drains. Drain is held off during reset so
  // a reset edge never commits a write.
  always_comb begin
    ready = 1'b0;
    if (state_q == RUN) begin
      ready = bus.cpu_req_write ? !full : load_ok;
    end
    store_acc = bus.cpu_req_valid &  bus.cpu_req_write & ready;
    load_acc  = bus.cpu_req_valid & !bus.cpu_req_write & ready;
    drain     = rst_n & !load_acc & !empty;

    bus.mem_read_write = drain;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    if (load_acc) begin
      bus.mem_address = bus.cpu_req_addr;
    end else if (drain) begin
      bus.mem_address    = entry_q[head_q].addr;
      bus.mem_write_data = entry_q[head_q].data;
    end
  end

  // Next-state logic for the run/flush controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   if (count_q == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register and the flush completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= (state_q == FLUSH) && (count_q == '0);
    end
  end

  // FIFO pointers, occupancy and registered load return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      if (store_acc) tail_q <= tail_q + PW'(1);
      if (drain)     head_q <= head_q + PW'(1);
      unique case ({store_acc, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      rdata_valid_q <= load_acc;
      if (load_acc) rdata_q <= load_data;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      entry_q[tail_q] <= '{addr: bus.cpu_req_addr, data: bus.cpu_req_wdata};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       flush_done;
  logic       full;
  logic       empty;
  logic [2:0] count;

  store_buffer_if #(.AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .flush_done (flush_done),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, write at the edge.
  bit [7:0] env_mem [256];
  always @(posedge clk) begin
    if (bus.mem_read_write === 1'b1) env_mem[bus.mem_address] <= bus.mem_write_data;
  end
  assign bus.mem_read_data = env_mem[bus.mem_address];

  // Reference model state.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;
  ent_t       pend [$];
  bit   [7:0] ref_mem [256];
  bit         flushing = 1'b0;
  logic       exp_rv = 1'b0;
  logic [7:0] exp_rd = 8'h00;
  logic       exp_fd = 1'b0;
  int         ntests = 0;
  int         nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_match(input logic [7:0] a);
    foreach (pend[i]) if (pend[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] youngest(input logic [7:0] a);
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].a == a) return pend[i].d;
    return 8'h00;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input bit r, input bit v, input bit w,
                      input logic [7:0] a, input logic [7:0] d, input bit f);
    bit   hit, rdy, lacc, sacc, drn;
    int   sz;
    ent_t h;
    @(negedge clk);
    rst_n             = r;
    bus.cpu_req_valid = v;
    bus.cpu_req_write = w;
    bus.cpu_req_addr  = a;
    bus.cpu_req_wdata = d;
    flush             = f;
    #1;
    sz = pend.size();
    chk("rdata_valid", 32'(bus.cpu_rdata_valid), 32'(exp_rv));
    chk("rdata",       32'(bus.cpu_rdata),       32'(exp_rd));
    chk("flush_done",  32'(flush_done),          32'(exp_fd));
    chk("count",       32'(count),               32'(sz));
    chk("full",        32'(full),                32'(sz == DEPTH));
    chk("empty",       32'(empty),               32'(sz == 0));
    hit = has_match(a);
    if (flushing) rdy = 1'b0;
    else if (w)   rdy = (sz < DEPTH);
    else          rdy = FWD || !hit;
    chk("ready", 32'(bus.cpu_req_ready), 32'(rdy));
    lacc = v && !w && rdy;
    sacc = v &&  w && rdy;
    drn  = r && !lacc && (sz > 0);
    chk("mem_rw", 32'(bus.mem_read_write), 32'(drn));
    if (lacc) begin
      chk("mem_addr_load", 32'(bus.mem_address), 32'(a));
    end else if (drn) begin
      chk("mem_addr_drain", 32'(bus.mem_address),    32'(pend[0].a));
      chk("mem_wdata",      32'(bus.mem_write_data), 32'(pend[0].d));
    end else begin
      chk("mem_addr_idle", 32'(bus.mem_address), 32'(0));
    end
    if (!r) begin
      pend.delete();
      flushing = 1'b0;
      exp_rv   = 1'b0;
      exp_rd   = 8'h00;
      exp_fd   = 1'b0;
    end else begin
      exp_rv = lacc;
      if (lacc) exp_rd = (FWD && hit) ? youngest(a) : ref_mem[a];
      exp_fd   = flushing && (sz == 0);
      flushing = flushing ? (sz != 0) : f;
      if (drn) begin
        h = pend.pop_front();
        ref_mem[h.a] = h.d;
      end
      if (sacc) pend.push_back('{a, d});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_write = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    repeat (2) @(posedge clk);

    // Reset state.
    idle(1);

    // Back-to-back stores, then idle until drained.
    step(1'b1, 1'b1, 1'b1, 8'h64, 8'hAA, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h65, 8'hBB, 1'b0);
    idle(3);
    chk("mem_64", 32'(env_mem[8'h64]), 32'h0AA);
    chk("mem_65", 32'(env_mem[8'h65]), 32'h0BB);

    // Stores interleaved with loads to 0x10.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 8'($urandom), 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 8'h44, 8'h3C, 1'b0);
    idle(5);

    // Same-address stores followed by an immediate load.
    step(1'b1, 1'b1, 1'b1, 8'h66, 8'h11, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h66, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h66, 8'h00, 1'b0);
    idle(2);
    chk("load_66", 32'(bus.cpu_rdata), 32'h022);

    // Load from memory with an empty buffer.
    step(1'b1, 1'b1, 1'b1, 8'h20, 8'h5A, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    idle(2);
    chk("load_20", 32'(bus.cpu_rdata), 32'h05A);

    // Stores then flush, flush while empty, flush held high.
    step(1'b1, 1'b1, 1'b1, 8'h30, 8'h01, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h31, 8'h02, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h32, 8'h03, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'h33, 8'h04, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    idle(3);

    // Reset in the middle of a drain.
    step(1'b1, 1'b1, 1'b1, 8'h70, 8'hC1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h71, 8'hC2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(3);
    chk("mem_71_discarded", 32'(env_mem[8'h71]), 32'h000);

    // Random traffic over a small address window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      step(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'(8'h60 + $urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 24) == 0));
    end
    idle(6);

    // Committed memory image.
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("mem_%0h", i), 32'(env_mem[i]), 32'(ref_mem[i]));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-buffering stage placed directly upstream of the single-cycle data memory. It accepts load/store requests from the datapath, parks stores in a small in-order FIFO, and drains them into memory one per cycle when the memory port is free. Loads get priority on the port, are checked against pending stores (forwarded or stalled), and return registered data. A flush input empties the buffer before system events.

## Interface
Parameters:
- DEPTH, 4, store entries (power of two, ≥2)
- AW, 8, address width
- DW, 8, data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- cpu_req_valid  in  1  request present
- cpu_req_write  in  1  1 = store, 0 = load
- cpu_req_addr  in  AW  request address
- cpu_req_wdata  in  DW  store data
- cpu_req_ready  out  1  request accepted this cycle when valid & ready
- cpu_rdata  out  DW  load result, registered
- cpu_rdata_valid  out  1  one-cycle pulse, cpu_rdata valid
- flush  in  1  level; request to empty buffer
- flush_done  out  1  one-cycle pulse when flush completes
- mem_address  out  AW  to memory address
- mem_write_data  out  DW  to memory write data
- mem_read_write  out  1  1 = write at next edge, 0 = read
- mem_read_data  in  DW  combinational memory read data
- count  out  log2(DEPTH)+1  entries held
- full, empty  out  1  count==DEPTH / count==0

## Operation
- FIFO: head/tail pointers wrap modulo DEPTH; count tracks occupancy (no pointer-compare ambiguity).
- Store accept: valid & write & state==RUN & !full. No same-cycle bypass: full stalls store even if draining.
- Load accept: valid & !write & state==RUN (plus forwarding rule below).
- Port priority: accepted load owns port (mem_read_write=0, mem_address=cpu_req_addr). Otherwise, if !empty, drain head (mem_read_write=1, address/data from head; head advances at edge). Otherwise mem_read_write=0, mem_address=0.
- Load data: youngest matching entry if hit, else mem_read_data; captured into cpu_rdata at edge, cpu_rdata_valid=1 next cycle.
- Simultaneous store accept and drain: count unchanged, both pointers advance.
- FSM: RUN → FLUSH when flush=1 (at edge). FLUSH: cpu_req_ready=0, drains every cycle. FLUSH → RUN when count==0 at edge; flush_done pulses the cycle after. flush asserted while empty: one FLUSH cycle, then done. flush held high after done re-enters FLUSH.

## Timing
- Reset (rst_n=0 at edge): count=0, pointers=0, state=RUN, cpu_rdata=0, cpu_rdata_valid=0, flush_done=0; hence empty=1, full=0, mem_read_write=0, mem_address=0, cpu_req_ready=1. Pending stores discarded; reset mid-drain writes nothing further.
- Load latency 1 cycle (accept edge → valid). Store accept-to-memory-write ≥1 cycle, FIFO order guaranteed.
- cpu_req_ready is combinational from state, count, request fields; never depends on cpu_req_valid handshake history.
- Drain rate: one entry per cycle without loads; continuous loads starve drain (intended).

## Configuration
- SB_FORWARD_EN defined: load matching any pending entry returns youngest matching data, accepted immediately.
- Undefined: matching load deasserts cpu_req_ready; port is free, so drains continue until no match, then load proceeds from memory. No address comparators feed data path.

## Structure
- Package sb_pkg: state enum (RUN, FLUSH), entry struct {addr, data}, default AW/DW/DEPTH constants.
- Sub-module sb_match: parallel address compare over valid entries, returns hit flag and youngest-hit index relative to tail; used for both forwarding and stall.

## Test plan
- Reset, then store (0x64,0xAA),(0x65,0xBB) back-to-back, idle → memory writes 0x64=0xAA then 0x65=0xBB on consecutive edges; empty returns to 1.
- Four stores with continuous loads to 0x10 → full=1, fifth store sees ready=0; stop loads → drain resumes, count falls 4→0 in 4 cycles.
- Store (0x66,0x11) then (0x66,0x22), immediate load 0x66 → with SB_FORWARD_EN cpu_rdata=0x22 one cycle later; without, ready=0 until both drained, then 0x22 from memory.
- Load 0x20 (memory holds 0x5A), buffer empty → cpu_rdata=0x5A, cpu_rdata_valid pulses exactly one cycle.
- Three stores then flush=1 → ready=0, three write cycles, flush_done pulses once, ready returns 1.
- Two stores, rst_n=0 one cycle mid-drain → count=0, no further memory writes, outputs at reset values.
